// File: rtl/seq_muldiv_unit.sv
// Iterative radix-2 RV32M-style multiply/divide unit (shift-add MUL, restoring DIV) with start/done handshake.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies skip CALC.
module seq_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iStart,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oReady,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [WIDTH-1:0] ZEROS = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MINV  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_a;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_divz;
  logic             r_ovf;
  logic             r_zero;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_is_div;
  logic             w_sgn_a;
  logic             w_sgn_b;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_mul_zero;
  logic             w_skip;

  // Operand decode: signedness, magnitudes and corner-case detection for LOAD
  always_comb begin
    w_is_div = iOp[2];
    w_sgn_a  = 1'b0;
    w_sgn_b  = 1'b0;
    case (iOp)
      OP_MUL, OP_MULH: begin
        w_sgn_a = 1'b1;
        w_sgn_b = 1'b1;
      end
      OP_MULHSU: begin
        w_sgn_a = 1'b1;
        w_sgn_b = 1'b0;
      end
      OP_DIV, OP_REM: begin
        w_sgn_a = 1'b1;
        w_sgn_b = 1'b1;
      end
      default: begin
        w_sgn_a = 1'b0;
        w_sgn_b = 1'b0;
      end
    endcase
    w_a_neg    = w_sgn_a & iA[WIDTH-1];
    w_b_neg    = w_sgn_b & iB[WIDTH-1];
    w_a_mag    = w_a_neg ? (~iA + WIDTH'(1)) : iA;
    w_b_mag    = w_b_neg ? (~iB + WIDTH'(1)) : iB;
    w_b_zero   = (iB == ZEROS);
    w_ovf      = w_is_div & w_sgn_a & (iA == MINV) & (iB == ONES);
    w_mul_zero = ~w_is_div & ((iA == ZEROS) | w_b_zero);
`ifdef MULDIV_EARLY_OUT_EN
    w_skip     = w_is_div ? (w_b_zero | w_ovf) : w_mul_zero;
`else
    w_skip     = 1'b0;
`endif
  end

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    w_add    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {1'b0, ZEROS});
    w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, r_m};
    w_q_bit  = (w_rem_sh >= {1'b0, r_m});
    if (r_op[2]) begin
      w_hi_nxt = w_q_bit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_q_bit};
    end else begin
      w_hi_nxt = w_add[WIDTH:1];
      w_lo_nxt = {w_add[0], r_lo[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_result;

  // Sign correction and result selection, including the architectural corner values
  always_comb begin
    w_prod     = {r_hi, r_lo};
    w_prod_fix = r_neg_q ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
    w_quo_fix  = r_neg_q ? (~r_lo + WIDTH'(1)) : r_lo;
    w_rem_fix  = r_neg_r ? (~r_hi + WIDTH'(1)) : r_hi;
    case (r_op)
      OP_MUL:                      w_result = r_zero ? ZEROS : w_prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_result = r_zero ? ZEROS : w_prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV:  w_result = r_divz ? ONES : (r_ovf ? MINV : w_quo_fix);
      OP_DIVU: w_result = r_divz ? ONES : r_lo;
      OP_REM:  w_result = r_divz ? r_a : (r_ovf ? ZEROS : w_rem_fix);
      OP_REMU: w_result = r_divz ? r_a : r_hi;
      default: w_result = ZEROS;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state  <= S_IDLE;
      r_op     <= 3'b000;
      r_m      <= ZEROS;
      r_hi     <= ZEROS;
      r_lo     <= ZEROS;
      r_a      <= ZEROS;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_divz   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_cnt    <= {CW{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= ZEROS;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (iStart) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          r_op    <= iOp;
          r_a     <= iA;
          r_hi    <= ZEROS;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_divz  <= w_is_div & w_b_zero;
          r_ovf   <= w_ovf;
          r_zero  <= w_mul_zero;
          r_cnt   <= CW'(WIDTH);
          if (w_is_div) begin
            r_m  <= w_b_mag;
            r_lo <= w_a_mag;
          end else begin
            r_m  <= w_a_mag;
            r_lo <= w_b_mag;
          end
          r_state <= w_skip ? S_FIX : S_CALC;
        end
        S_CALC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_FIX: begin
          r_result <= w_result;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign oBusy   = r_busy;
  assign oReady  = ~r_busy;
  assign oDone   = r_done;
  assign oResult = r_result;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed self-checking bench for seq_muldiv_unit (WIDTH=32): results, latency, handshake and reset.
module tb_seq_muldiv_unit;

  logic        iCLK;
  logic        iRST_n;
  logic        iStart;
  logic [2:0]  iOp;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        oReady;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;

  int total = 0;
  int bad   = 0;

  localparam int LAT_FULL = 34;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_FAST = 2;
`else
  localparam int LAT_FAST = 34;
`endif

  seq_muldiv_unit #(.WIDTH(32)) dut (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .iStart  (iStart),
    .iOp     (iOp),
    .iA      (iA),
    .iB      (iB),
    .oReady  (oReady),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oResult (oResult)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Issue one op and count edges from the accepting edge until oDone is seen
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit toggle, output logic [31:0] res, output int lat, output bit got);
    @(negedge iCLK);
    iStart = 1'b1;
    iOp    = op;
    iA     = a;
    iB     = b;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge iCLK);
      lat++;
      #1;
      if (oDone) got = 1'b1;
      if (toggle && lat >= 1) begin
        iA  = $urandom;
        iB  = $urandom;
        iOp = 3'($urandom_range(7, 0));
      end
    end
    res = oResult;
  endtask

  task automatic test_reset();
    total++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'h0 || oReady !== 1'b1) begin
      bad++;
      $display("FAIL reset busy=%b done=%b res=%h ready=%b exp 0 0 0 1", oBusy, oDone, oResult, oReady);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'b000, 3'b011, 3'b001, 3'b010};
    logic [31:0] as  [4] = '{32'h7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] exps[4] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF};
    logic [31:0] r;
    int lat;
    bit got;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, r, lat, got);
      total++;
      if (!got || r !== exps[i]) begin
        bad++;
        $display("FAIL mul_%0d result got=%h done=%b exp=%h", i, r, got, exps[i]);
      end
      total++;
      if (lat !== LAT_FULL) begin
        bad++;
        $display("FAIL mul_%0d latency got=%0d exp=%0d", i, lat, LAT_FULL);
      end
    end
    run_op(3'b000, 32'h0, 32'h5, 1'b0, r, lat, got);
    total++;
    if (!got || r !== 32'h0 || lat !== LAT_FAST) begin
      bad++;
      $display("FAIL mul_zero got=%h lat=%0d exp=0 lat=%0d", r, lat, LAT_FAST);
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exps[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    logic [31:0] r;
    int lat;
    bit got;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, r, lat, got);
      total++;
      if (!got || r !== exps[i] || lat !== LAT_FULL) begin
        bad++;
        $display("FAIL div_%0d got=%h lat=%0d exp=%h lat=%0d", i, r, lat, exps[i], LAT_FULL);
      end
    end
  endtask

  task automatic test_div_corner();
    logic [2:0]  ops [6] = '{3'b100, 3'b111, 3'b100, 3'b110, 3'b110, 3'b100};
    logic [31:0] as  [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFB};
    logic [31:0] bs  [6] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic [31:0] exps[6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF};
    logic [31:0] r;
    int lat;
    bit got;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, r, lat, got);
      total++;
      if (!got || r !== exps[i]) begin
        bad++;
        $display("FAIL corner_%0d result got=%h done=%b exp=%h", i, r, got, exps[i]);
      end
      total++;
      if (lat !== LAT_FAST) begin
        bad++;
        $display("FAIL corner_%0d latency got=%0d exp=%0d", i, lat, LAT_FAST);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int lat;
    bit got;
    run_op(3'b101, 32'd1000, 32'd10, 1'b0, r, lat, got);
    total++;
    if (!got || r !== 32'd100 || oReady !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first got=%h ready=%b exp=%h ready=1", r, oReady, 32'd100);
    end
    run_op(3'b000, 32'd12, 32'd13, 1'b0, r, lat, got);
    total++;
    if (!got || r !== 32'd156 || lat !== LAT_FULL) begin
      bad++;
      $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=%0d", r, lat, 32'd156, LAT_FULL);
    end
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    int first = 0;
    logic [31:0] r = 32'h0;
    @(negedge iCLK);
    iStart = 1'b1;
    iOp    = 3'b011;
    iA     = 32'h12345678;
    iB     = 32'h10;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge iCLK);
      #1;
      if (oDone) begin
        dones++;
        if (first == 0) begin
          first = c;
          r = oResult;
        end
      end
      if (c == 4) begin
        iStart = 1'b1;
        iOp    = 3'b000;
        iA     = 32'h3;
        iB     = 32'h3;
      end else if (c == 5) begin
        iStart = 1'b0;
      end
    end
    total++;
    if (dones !== 1 || first !== LAT_FULL || r !== 32'h1) begin
      bad++;
      $display("FAIL busy_ignore dones=%0d at=%0d res=%h exp 1 at %0d res=00000001", dones, first, r, LAT_FULL);
    end
  endtask

  task automatic test_operand_change();
    logic [31:0] r;
    int lat;
    bit got;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 1'b1, r, lat, got);
    total++;
    if (!got || r !== 32'hFFFFFFFD || lat !== LAT_FULL) begin
      bad++;
      $display("FAIL operand_change got=%h lat=%0d exp=FFFFFFFD lat=%0d", r, lat, LAT_FULL);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    logic [31:0] r;
    int lat;
    bit got;
    @(negedge iCLK);
    iStart = 1'b1;
    iOp    = 3'b000;
    iA     = 32'd9;
    iB     = 32'd9;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    repeat (10) @(posedge iCLK);
    #1;
    iRST_n = 1'b0;
    #1;
    total++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid busy=%b done=%b res=%h exp 0 0 0", oBusy, oDone, oResult);
    end
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge iCLK);
      #1;
      if (oDone || oBusy) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL reset_no_done activity=%0d exp=0", dones);
    end
    run_op(3'b101, 32'd100, 32'd7, 1'b0, r, lat, got);
    total++;
    if (!got || r !== 32'd14 || lat !== LAT_FULL) begin
      bad++;
      $display("FAIL reset_recover got=%h lat=%0d exp=0000000e lat=%0d", r, lat, LAT_FULL);
    end
  endtask

  initial begin
    iRST_n = 1'b0;
    iStart = 1'b0;
    iOp    = 3'b000;
    iA     = 32'h0;
    iB     = 32'h0;
    repeat (3) @(posedge iCLK);
    #1;
    test_reset();
    @(negedge iCLK);
    iRST_n = 1'b1;
    test_mul();
    test_div();
    test_div_corner();
    test_back_to_back();
    test_busy_ignore();
    test_operand_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
